fir_mac_seq: RTL and testbench

//  Parametrised, time-multiplexed FIR filter: one multiplier-accumulator shared across NTAPS taps.

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_mac_sat.sv | 29 ++
 rtl/fir_mac_seq.sv | 97 +++++++++
 tb/tb_fir_mac_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state encoding and constant clog2 helper for the time-multiplexed FIR
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/fir_mac_sat.sv
// fir_mac_sat: combinational multiply-accumulate step plus round, shift and saturate of the result
//   acc_i  current accumulator           x_i/h_i  sample and coefficient of this tap
//   acc_o  acc_i + x_i*h_i               y_o      acc_o rounded half-up, >>> SHIFT, clamped or wrapped to OW
module fir_mac_sat #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 19,
  parameter int OW = 16,
  parameter int SHIFT = 0,
  parameter int SAT = 1
) (
  input  logic signed [AW-1:0] acc_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [CW-1:0] h_i,
  output logic signed [AW-1:0] acc_o,
  output logic [OW-1:0]        y_o
);
  // Wide enough that rounding never overflows and every OW bound is representable.
  localparam int WW = AW + OW + 2;
  localparam logic signed [WW-1:0] HALF = (WW'(1) << SHIFT) >> 1;
  localparam logic signed [WW-1:0] MAXV = {{(WW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = ~MAXV;
  logic signed [DW+CW-1:0] prod;
  logic signed [WW-1:0] r;
  assign prod = x_i * h_i;
  assign acc_o = acc_i + AW'(prod);
  assign r = (WW'(acc_o) + HALF) >>> SHIFT;
  assign y_o = (SAT != 0) ? ((r > MAXV) ? MAXV[OW-1:0] : (r < MINV) ? MINV[OW-1:0] : r[OW-1:0]) : r[OW-1:0];
endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR, one shared MAC over NTAPS taps with programmable coefficients
//   in_valid/in_ready/in_data       sample input handshake (accepted in IDLE when flush is low)
//   out_valid/out_ready/out_data    filtered output, held in OUT until out_ready
//   coef_we/coef_addr/coef_wdata    coefficient write, honoured in IDLE only (coef_wready)
//   flush                           clears sample history in IDLE
//   busy                            high while a sample is being processed
module fir_mac_seq import fir_pkg::*; #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int NTAPS = 8,
  parameter int OW = 16,
  parameter int SHIFT = 0,
  parameter int SAT = 1,
  localparam int KW = clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  input  logic          coef_we,
  input  logic [KW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          coef_wready,
  input  logic          flush,
  output logic          busy
);
  localparam int AW = DW + CW + KW;
  state_t state_q;
  logic signed [DW-1:0] x_q [NTAPS];
  logic signed [CW-1:0] h_q [NTAPS];
  logic signed [AW-1:0] acc_q, acc_d;
  logic [KW-1:0] k_q;
  logic [OW-1:0] out_q, y_d;
  logic out_valid_q;
  fir_mac_sat #(.DW(DW), .CW(CW), .AW(AW), .OW(OW), .SHIFT(SHIFT), .SAT(SAT)) u_dp (
    .acc_i(acc_q),
    .x_i(x_q[k_q]),
    .h_i(h_q[k_q]),
    .acc_o(acc_d),
    .y_o(y_d)
  );
  assign in_ready = (state_q == IDLE) && !flush;
  assign coef_wready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      k_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (coef_we && 32'(coef_addr) < NTAPS) h_q[coef_addr] <= coef_wdata;
          // flush wins over a simultaneous sample, which is then left unaccepted
          if (flush) begin
            for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
          end else if (in_valid) begin
            x_q[0] <= in_data;
            for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
            acc_q <= '0;
            k_q <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          k_q <= k_q + 1'b1;
          // the final tap's sum goes straight through the output stage
          if (k_q == KW'(NTAPS - 1)) begin
            out_q <= y_d;
            out_valid_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: scoreboard bench driving four NTAPS=4 configurations in lockstep
module tb_fir_mac_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, coef_we = 0, flush = 0;
  logic [7:0] in_data = 0, coef_wdata = 0;
  logic [1:0] coef_addr = 0;
  logic ov [4], ir [4], cw [4], bz [4];
  logic [15:0] od0, od3;
  logic [7:0] od1, od2;
  int got [4];
  int q [4][$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign got[0] = int'($signed(od0));
  assign got[1] = int'($signed(od1));
  assign got[2] = int'($signed(od2));
  assign got[3] = int'($signed(od3));
  fir_mac_seq #(.NTAPS(4)) u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wready(cw[0]), .flush(flush), .busy(bz[0]));
  fir_mac_seq #(.NTAPS(4), .OW(8)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wready(cw[1]), .flush(flush), .busy(bz[1]));
  fir_mac_seq #(.NTAPS(4), .OW(8), .SAT(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wready(cw[2]), .flush(flush), .busy(bz[2]));
  fir_mac_seq #(.NTAPS(4), .SHIFT(2)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_wready(cw[3]), .flush(flush), .busy(bz[3]));
  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int i = 0; i < 4; i++) begin
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_y%0d: got %0d, expected no output", i, got[i]);
          end else check($sformatf("y%0d", i), got[i], q[i].pop_front());
        end
      end
    end
  end
  task automatic wr(input int a, input int v);
    coef_we = 1;
    coef_addr = 2'(a);
    coef_wdata = 8'(v);
    @(posedge clk);
    #1 coef_we = 0;
  endtask
  task automatic do_flush();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
  endtask
  // act: 0 plain, 1 coef write during MAC, 2 reset in 2nd MAC cycle, 3 stall 10 cycles in OUT
  task automatic send(input int d, input int e0, input int e1, input int e2, input int e3, input int act);
    int n;
    in_data = 8'(d);
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    n = 1;
    if (act != 2) begin
      q[0].push_back(e0);
      q[1].push_back(e1);
      q[2].push_back(e2);
      q[3].push_back(e3);
    end
    if (act == 1) begin
      coef_we = 1;
      coef_addr = 0;
      coef_wdata = 8'd9;
      #1 check("coef_wready_in_mac", int'(cw[0]), 0);
      check("busy_in_mac", int'(bz[0]), 1);
      @(posedge clk);
      #1 coef_we = 0;
      n++;
    end
    if (act == 2) begin
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      check("busy_after_rst", int'(bz[0]), 0);
      check("in_ready_after_rst", int'(ir[0]), 1);
      check("out_valid_after_rst", int'(ov[0]), 0);
      repeat (8) begin
        @(posedge clk);
        #1 check("no_out_after_rst", int'(ov[0]), 0);
      end
      return;
    end
    if (act == 3) out_ready = 0;
    while (!ov[0] && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", n, 5);
    if (act == 3) begin
      repeat (10) begin
        @(posedge clk);
        #1 check("stall_data", got[0], e0);
        check("stall_in_ready", int'(ir[0]), 0);
        check("stall_valid", int'(ov[0]), 1);
      end
      out_ready = 1;
    end
    @(posedge clk);
    #1 check("out_valid_drop", int'(ov[0]), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_out_valid%0d", i), int'(ov[i]), 0);
      check($sformatf("rst_out_data%0d", i), got[i], 0);
      check($sformatf("rst_busy%0d", i), int'(bz[i]), 0);
      check($sformatf("rst_in_ready%0d", i), int'(ir[i]), 1);
      check($sformatf("rst_coef_wready%0d", i), int'(cw[i]), 1);
    end
    rst = 0;
    // impulse response through h = {1,2,3,4}
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    send(1, 1, 1, 1, 0, 0);
    send(0, 2, 2, 2, 1, 0);
    send(0, 3, 3, 3, 1, 0);
    send(0, 4, 4, 4, 1, 0);
    send(0, 0, 0, 0, 0, 0);
    // full-scale input on full-scale taps: saturation versus wrap
    for (int k = 0; k < 4; k++) wr(k, 127);
    do_flush();
    send(127, 16129, 127, 1, 4032, 0);
    send(127, 32258, 127, 2, 8065, 0);
    send(127, 32767, 127, 3, 12097, 0);
    send(127, 32767, 127, 4, 16129, 0);
    // round-half-up shift
    wr(0, 1); wr(1, 0); wr(2, 0); wr(3, 0);
    send(6, 6, 6, 6, 2, 0);
    send(-6, -6, -6, -6, -1, 0);
    // output back-pressure
    send(5, 5, 5, 5, 1, 3);
    // write attempted during MAC is dropped
    send(3, 3, 3, 3, 1, 1);
    // flush beats a simultaneous sample
    for (int k = 0; k < 4; k++) wr(k, 1);
    flush = 1;
    in_valid = 1;
    in_data = 8'd100;
    #1 check("in_ready_flush", int'(ir[0]), 0);
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    check("flush_not_accepted", int'(bz[0]), 0);
    send(7, 7, 7, 7, 2, 0);
    // reset mid-MAC, then coefficients read back as zero
    send(1, 0, 0, 0, 0, 2);
    send(1, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("queue_empty%0d", i), q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
